uart_rx_cfg: RTL and testbench

// Parametrised UART receiver. Successor to the fixed 8-bit, odd-parity peripheral receiver.

---
 rtl/uart_rx_cfg.sv | 221 ++++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: 2-flop synchroniser, oversampled start validation,
// LSB-first data, optional parity, 1/2 stop bits. Define UART_RX_MAJORITY_VOTE_EN for 3-sample voting.
module uart_rx_cfg #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned OVS       = 8,
  parameter int unsigned PARITY    = 1,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick_i,
  input  logic                 rx_i,
  input  logic                 full_i,
  output logic                 we_o,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int unsigned CW = $clog2(OVS);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVS - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam logic [CW-1:0] CNT_DEC = CW'(OVS / 2);
  localparam logic [CW-1:0] CNT_V0  = CW'(OVS / 2 - 2);
  localparam logic [CW-1:0] CNT_V1  = CW'(OVS / 2 - 1);
`else
  localparam logic [CW-1:0] CNT_DEC   = CNT_LAST;
  localparam logic [CW-1:0] CNT_START = CW'(OVS / 2 - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bitn_q, bitn_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 par_q, par_d;
  logic                 stop_err_q, stop_err_d;
  logic                 we_q, we_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 sync1_q, sync2_q;
  logic                 rx_s;
  logic                 samp;
  logic                 par_bad;
  logic                 frame_bad;

  assign rx_s = sync2_q;

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0] vote_q, vote_d;

  assign samp = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s) | (vote_q[1] & rx_s);
`else
  assign samp = rx_s;
`endif

  always_comb begin
    if (PARITY == 1)      par_bad = ((^shift_q) ^ par_q) != 1'b1;
    else if (PARITY == 2) par_bad = ((^shift_q) ^ par_q) != 1'b0;
    else                  par_bad = 1'b0;
  end

  assign frame_bad = stop_err_q | ~samp;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bitn_d     = bitn_q;
    shift_d    = shift_q;
    data_d     = data_q;
    par_d      = par_q;
    stop_err_d = stop_err_q;
    we_d       = 1'b0;
    perr_d     = 1'b0;
    ferr_d     = 1'b0;
    ovr_d      = 1'b0;
`ifdef UART_RX_MAJORITY_VOTE_EN
    vote_d     = vote_q;
`endif
    if (tick_i) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
`ifdef UART_RX_MAJORITY_VOTE_EN
      if (cnt_q == CNT_V0) vote_d[0] = rx_s;
      if (cnt_q == CNT_V1) vote_d[1] = rx_s;
`endif
      case (state_q)
        S_IDLE: begin
          cnt_d      = '0;
          bitn_d     = '0;
          stop_err_d = 1'b0;
          if (!rx_s) state_d = S_START;
        end
        S_START: begin
`ifdef UART_RX_MAJORITY_VOTE_EN
          // Vote ends past mid-bit; the start bit runs its full period so later windows stay bit-aligned.
          if (cnt_q == CNT_DEC && samp) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = S_DATA;
          end
`else
          if (cnt_q == CNT_START) begin
            cnt_d   = '0;
            state_d = rx_s ? S_IDLE : S_DATA;
          end
`endif
        end
        S_DATA: begin
          if (cnt_q == CNT_DEC) begin
            shift_d = {samp, shift_q[DATA_BITS-1:1]};
            bitn_d  = bitn_q + 1'b1;
          end
          if (cnt_q == CNT_LAST && bitn_d == BIT_LAST) begin
            bitn_d  = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          if (cnt_q == CNT_DEC)  par_d   = samp;
          if (cnt_q == CNT_LAST) state_d = S_STOP;
        end
        S_STOP: begin
          if (cnt_q == CNT_DEC) begin
            if (bitn_q == STOP_LAST) begin
              cnt_d  = '0;
              bitn_d = '0;
              if (frame_bad) begin
                ferr_d  = 1'b1;
                state_d = S_BREAK;
              end else if (par_bad) begin
                perr_d  = 1'b1;
                state_d = S_IDLE;
              end else if (full_i) begin
                ovr_d   = 1'b1;
                state_d = S_IDLE;
              end else begin
                we_d    = 1'b1;
                data_d  = shift_q;
                state_d = S_IDLE;
              end
            end else begin
              stop_err_d = frame_bad;
              bitn_d     = bitn_q + 1'b1;
            end
          end
        end
        S_BREAK: begin
          cnt_d = '0;
          if (rx_s) state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bitn_q     <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      par_q      <= 1'b0;
      stop_err_q <= 1'b0;
      we_q       <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
`ifdef UART_RX_MAJORITY_VOTE_EN
      vote_q     <= '1;
`endif
    end else begin
      sync1_q    <= rx_i;
      sync2_q    <= sync1_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bitn_q     <= bitn_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      par_q      <= par_d;
      stop_err_q <= stop_err_d;
      we_q       <= we_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
`ifdef UART_RX_MAJORITY_VOTE_EN
      vote_q     <= vote_d;
`endif
    end
  end

  assign we_o         = we_q;
  assign data_o       = data_q;
  assign parity_err_o = perr_q;
  assign frame_err_o  = ferr_q;
  assign overrun_o    = ovr_q;
  assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: default instance (8O1, OVS=8) and a 7E2/OVS=16 instance,
// directed scenarios plus random frames against a frame-level outcome model.
module tb_uart_rx_cfg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, tick_i, full_i, rx_a, rx_b;
  logic       we_a, perr_a, ferr_a, ovr_a, busy_a;
  logic [7:0] data_a;
  logic       we_b, perr_b, ferr_b, ovr_b, busy_b;
  logic [6:0] data_b;

  uart_rx_cfg #(.DATA_BITS(8), .OVS(8), .PARITY(1), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .tick_i(tick_i), .rx_i(rx_a), .full_i(full_i),
    .we_o(we_a), .data_o(data_a), .parity_err_o(perr_a), .frame_err_o(ferr_a),
    .overrun_o(ovr_a), .busy_o(busy_a)
  );

  uart_rx_cfg #(.DATA_BITS(7), .OVS(16), .PARITY(2), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .tick_i(tick_i), .rx_i(rx_b), .full_i(full_i),
    .we_o(we_b), .data_o(data_b), .parity_err_o(perr_b), .frame_err_o(ferr_b),
    .overrun_o(ovr_b), .busy_o(busy_b)
  );

  int checks = 0;
  int errors = 0;
  int div    = 1;

  // Observed pulse counts per instance; "bad" counts strobes overlapping errors or lasting >1 clk.
  int got_we[2], got_pe[2], got_fe[2], got_ov[2], got_bad[2];
  int exp_we[2], exp_pe[2], exp_fe[2], exp_ov[2];
  logic [8:0] exp_data[2];
  logic [3:0] prev_a = '0, prev_b = '0;

  always @(negedge clk) begin
    if (we_a)   got_we[0]++;
    if (perr_a) got_pe[0]++;
    if (ferr_a) got_fe[0]++;
    if (ovr_a)  got_ov[0]++;
    if ((we_a && (perr_a || ferr_a || ovr_a)) || ((prev_a & {we_a, perr_a, ferr_a, ovr_a}) != 4'd0))
      got_bad[0]++;
    prev_a = {we_a, perr_a, ferr_a, ovr_a};
    if (we_b)   got_we[1]++;
    if (perr_b) got_pe[1]++;
    if (ferr_b) got_fe[1]++;
    if (ovr_b)  got_ov[1]++;
    if ((we_b && (perr_b || ferr_b || ovr_b)) || ((prev_b & {we_b, perr_b, ferr_b, ovr_b}) != 4'd0))
      got_bad[1]++;
    prev_b = {we_b, perr_b, ferr_b, ovr_b};
  end

  initial begin
    #10ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    tick_i = (div == 2) ? ~tick_i : 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic set_rx(input int sel, input logic v);
    if (sel == 0) rx_a = v;
    else          rx_b = v;
  endtask

  task automatic send_frame(input int sel, input logic [8:0] d, input logic par_ok,
                            input logic [1:0] stop_bad, input int glitch_bit);
    logic bits[$];
    int db, ovs, ones;
    logic p;
    db  = (sel == 0) ? 8 : 7;
    ovs = (sel == 0) ? 8 : 16;
    bits.push_back(1'b0);
    for (int i = 0; i < db; i++) bits.push_back(d[i]);
    ones = 0;
    for (int i = 0; i < db; i++) ones += int'(d[i]);
    // Instance A is odd parity, instance B even parity.
    p = (sel == 0) ? ((ones % 2) == 0) : ((ones % 2) == 1);
    if (!par_ok) p = ~p;
    bits.push_back(p);
    for (int i = 0; i < ((sel == 0) ? 1 : 2); i++) bits.push_back(~stop_bad[i]);
    for (int i = 0; i < bits.size(); i++)
      for (int c = 0; c < ovs * div; c++) begin
        set_rx(sel, (i == glitch_bit && c == ovs / 2) ? ~bits[i] : bits[i]);
        cyc();
      end
    set_rx(sel, 1'b1);
  endtask

  task automatic verify(input int sel, input string tag);
    logic [8:0] gd;
    logic       gb;
    gd = (sel == 0) ? {1'b0, data_a} : {2'b00, data_b};
    gb = (sel == 0) ? busy_a : busy_b;
    check({tag, ".we"},   got_we[sel], exp_we[sel]);
    check({tag, ".perr"}, got_pe[sel], exp_pe[sel]);
    check({tag, ".ferr"}, got_fe[sel], exp_fe[sel]);
    check({tag, ".ovr"},  got_ov[sel], exp_ov[sel]);
    check({tag, ".data"}, gd, exp_data[sel]);
    check({tag, ".busy"}, gb, 1'b0);
  endtask

  // Frame-level model: first failing rule in priority order decides the single outcome.
  task automatic model(input int sel, input logic [8:0] d, input logic par_ok,
                       input logic [1:0] stop_bad, input logic full, input logic corrupt);
    logic [8:0] mask;
    mask = (sel == 0) ? 9'h0ff : 9'h07f;
    if (stop_bad != 2'b00)        exp_fe[sel]++;
    else if (par_ok == corrupt)   exp_pe[sel]++;
    else if (full)                exp_ov[sel]++;
    else begin
      exp_we[sel]++;
      exp_data[sel] = d & mask;
    end
  endtask

  task automatic frame(input int sel, input logic [8:0] d, input logic par_ok,
                       input logic [1:0] stop_bad, input logic full, input int gap, input string tag);
    full_i = full;
    send_frame(sel, d, par_ok, stop_bad, -1);
    full_i = 1'b0;
    idle(gap);
    model(sel, d, par_ok, stop_bad, full, 1'b0);
    verify(sel, tag);
  endtask

  initial begin
    logic [8:0] d;
    logic       pok, full;
    logic [1:0] sbad;
    int         gap;

    for (int i = 0; i < 2; i++) begin
      got_we[i] = 0; got_pe[i] = 0; got_fe[i] = 0; got_ov[i] = 0; got_bad[i] = 0;
      exp_we[i] = 0; exp_pe[i] = 0; exp_fe[i] = 0; exp_ov[i] = 0; exp_data[i] = '0;
    end
    rst_n = 1'b0; tick_i = 1'b1; full_i = 1'b0; rx_a = 1'b1; rx_b = 1'b1;
    idle(4);
    verify(0, "reset_a");
    verify(1, "reset_b");
    rst_n = 1'b1;
    idle(4);

    // Basic 8O1 frames: good, bad parity, glitch start, break, overrun.
    frame(0, 9'h0A5, 1'b1, 2'b00, 1'b0, 6, "t1_good");
    frame(0, 9'h0A5, 1'b0, 2'b00, 1'b0, 6, "t2_parity");

    rx_a = 1'b0;
    idle(3);
    check("t3_busy_rise", busy_a, 1'b1);
    rx_a = 1'b1;
    idle(30);
    verify(0, "t3_glitch");
    frame(0, 9'h03C, 1'b1, 2'b00, 1'b0, 6, "t3_after");

    send_frame(0, 9'h055, 1'b1, 2'b01, -1);
    rx_a = 1'b0;
    idle(40);
    check("t4_busy_break", busy_a, 1'b1);
    rx_a = 1'b1;
    idle(6);
    model(0, 9'h055, 1'b1, 2'b01, 1'b0, 1'b0);
    verify(0, "t4_break");
    frame(0, 9'h001, 1'b1, 2'b00, 1'b0, 6, "t4_after");

    frame(0, 9'h07E, 1'b1, 2'b00, 1'b1, 6, "t5_overrun");
    frame(0, 9'h081, 1'b1, 2'b00, 1'b0, 6, "t5_after");

    // Back-to-back: second start edge immediately after the first stop bit.
    send_frame(0, 9'h012, 1'b1, 2'b00, -1);
    send_frame(0, 9'h0F0, 1'b1, 2'b00, -1);
    idle(6);
    model(0, 9'h012, 1'b1, 2'b00, 1'b0, 1'b0);
    model(0, 9'h0F0, 1'b1, 2'b00, 1'b0, 1'b0);
    verify(0, "b2b");

    // Random frames, first at clk-rate ticks, then with tick_i at half rate.
    for (int n = 0; n < 30; n++) begin
      div  = (n < 20) ? 1 : 2;
      d    = 9'($urandom_range(0, 255));
      pok  = ($urandom_range(0, 99) >= 15);
      sbad = {1'b0, ($urandom_range(0, 99) < 15)};
      full = ($urandom_range(0, 99) < 25);
      gap  = 6 + int'($urandom_range(0, 10));
      frame(0, d, pok, sbad, full, gap, "rand_a");
    end
    div = 1;

    // Reset in the middle of a frame aborts it silently and clears data_o.
    rx_a = 1'b0;
    idle(30);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy_a, 1'b0);
    rx_a = 1'b1;
    idle(3);
    rst_n = 1'b1;
    exp_data[0] = '0;
    idle(20);
    verify(0, "midrst");
    frame(0, 9'h05A, 1'b1, 2'b00, 1'b0, 6, "midrst_after");

    // 7E2, OVS=16 instance.
    frame(1, 9'h041, 1'b1, 2'b00, 1'b0, 8, "t6_good");
    frame(1, 9'h041, 1'b1, 2'b10, 1'b0, 8, "t6_stop2");
    send_frame(1, 9'h041, 1'b1, 2'b00, 2);
    idle(8);
`ifdef UART_RX_MAJORITY_VOTE_EN
    model(1, 9'h041, 1'b1, 2'b00, 1'b0, 1'b0);
`else
    model(1, 9'h041, 1'b1, 2'b00, 1'b0, 1'b1);
`endif
    verify(1, "t6_glitch");
    for (int n = 0; n < 6; n++) begin
      d    = 9'($urandom_range(0, 127));
      pok  = ($urandom_range(0, 99) >= 20);
      sbad = ($urandom_range(0, 99) < 25) ? 2'($urandom_range(1, 3)) : 2'b00;
      full = ($urandom_range(0, 99) < 20);
      frame(1, d, pok, sbad, full, 8, "rand_b");
    end

    check("strobe_a", got_bad[0], 0);
    check("strobe_b", got_bad[1], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
